// File: rtl/dac_seq_pkg.sv
// Shared constants, entry layout and width helper for the DAC sample sequencer.
package dac_seq_pkg;

  localparam int DATA_W_DEF     = 10;
  localparam int NUM_CH_DEF     = 2;
  localparam int FIFO_DEPTH_DEF = 8;

  // Channel-index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_W_DEF = clog2_min1(NUM_CH_DEF);

  typedef struct packed {
    logic [CH_W_DEF-1:0]   ch;
    logic [DATA_W_DEF-1:0] data;
  } dac_entry_t;

endpackage

// File: rtl/seq_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered occupancy count.
module seq_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Equal addresses: same lap means empty, lap bits differing means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + PTR_ONE;
        2'b01:   fill <= fill - PTR_ONE;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Buffers {channel, code} words from the core and releases one per rate tick
// into per-channel DAC code registers, with a one-cycle update pulse per load.
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int CH_W       = clog2_min1(NUM_CH),
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DIV_W      = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CH_W-1:0]            in_ch,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div,
  input  logic                       clr_underflow,
  output logic [NUM_CH*DATA_W-1:0]   dac_out,
  output logic [NUM_CH-1:0]          dac_update,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                       underflow
);

  localparam int FILL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = CH_W + DATA_W;
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0]  CNT_ONE   = 1;

  logic [DIV_W-1:0]   count;
  logic               tick;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic [CH_W-1:0]    pop_ch;
  logic [DATA_W-1:0]  pop_data;
  logic               ch_ok;

  // Handshake: a word transfers on a cycle where in_valid && in_ready. in_ready
  // comes only from registered fill, so it never reacts to in_valid or a pop
  // in the same cycle.
  assign in_ready = (fill != FULL_FILL);
  assign push     = in_valid && in_ready && !fifo_full;
  assign wdata    = {in_ch, in_data};

  assign tick     = en && (count >= div);
  assign pop      = tick && !fifo_empty;
  assign pop_ch   = rdata[ENTRY_W-1 -: CH_W];
  assign pop_data = rdata[DATA_W-1:0];
  assign ch_ok    = (int'(pop_ch) < NUM_CH);

  seq_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  // Rate divider: the >= compare lets a lowered div take effect mid-count.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dac_out    <= '0;
      dac_update <= '0;
    end else begin
      dac_update <= '0;
      if (pop && ch_ok) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (int'(pop_ch) == k) begin
            dac_out[k*DATA_W +: DATA_W] <= pop_data;
            dac_update[k]               <= 1'b1;
          end
        end
      end
    end
  end

  // A tick that finds nothing to send beats a simultaneous clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (tick && fifo_empty) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Randomized and directed bench for dac_sample_sequencer against a queue-based
// cycle model of the sequencer's rules.
module tb_dac_sample_sequencer;

  localparam int DATA_W = 10;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;
  localparam int FILL_W = 4;

  logic                     clk;
  logic                     reset;
  logic [DATA_W-1:0]        in_data;
  logic [CH_W-1:0]          in_ch;
  logic                     in_valid;
  logic                     in_ready;
  logic                     en;
  logic [DIV_W-1:0]         div;
  logic                     clr_underflow;
  logic [NUM_CH*DATA_W-1:0] dac_out;
  logic [NUM_CH-1:0]        dac_update;
  logic [FILL_W-1:0]        fill;
  logic                     underflow;

  dac_sample_sequencer #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .CLK           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_ch         (in_ch),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .en            (en),
    .div           (div),
    .clr_underflow (clr_underflow),
    .dac_out       (dac_out),
    .dac_update    (dac_update),
    .fill          (fill),
    .underflow     (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  typedef struct {
    int ch;
    int data;
  } ent_t;

  ent_t mq[$];
  ent_t feed_q[$];
  int   m_cnt;
  int   m_dac[NUM_CH];
  int   m_upd;
  bit   m_uf;
  logic [31:0] exp_q[$];

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare();
    logic [NUM_CH*DATA_W-1:0] ev;
    ev = '0;
    for (int k = 0; k < NUM_CH; k++) ev[k*DATA_W +: DATA_W] = DATA_W'(m_dac[k]);
    check("dac_out", 32'(dac_out), 32'(ev));
    check("dac_update", 32'(dac_update), 32'(m_upd));
    check("fill", 32'(fill), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // Advance model and DUT by one clock with the inputs currently driven.
  task automatic step();
    int   sz;
    bit   tk;
    bit   acc;
    ent_t e;
    sz  = mq.size();
    tk  = en && (m_cnt >= int'(div));
    acc = in_valid && (sz != DEPTH);
    m_upd = 0;
    if (tk && sz > 0) begin
      e = mq.pop_front();
      if (e.ch < NUM_CH) begin
        m_dac[e.ch] = e.data;
        m_upd = 1 << e.ch;
        exp_q.push_back(32'(e.data));
      end
    end
    if (acc) mq.push_back('{ch: int'(in_ch), data: int'(in_data)});
    if (tk && sz == 0) m_uf = 1'b1;
    else if (clr_underflow) m_uf = 1'b0;
    if (!en || tk) m_cnt = 0;
    else m_cnt++;
    @(posedge clk);
    #1;
    compare();
    // every update pulse must carry the next expected code in pop order
    for (int k = 0; k < NUM_CH; k++) begin
      if (dac_update[k]) begin
        if (exp_q.size() == 0) check("order_extra", 32'(dac_out[k*DATA_W +: DATA_W]), 32'hFFFF_FFFF);
        else check("order", 32'(dac_out[k*DATA_W +: DATA_W]), exp_q.pop_front());
      end
    end
  endtask

  // driver tasks
  task automatic run_feed(input int ncycles);
    bit v;
    bit a;
    for (int i = 0; i < ncycles; i++) begin
      v = (feed_q.size() > 0);
      in_valid = v;
      if (v) begin
        in_ch   = CH_W'(feed_q[0].ch);
        in_data = DATA_W'(feed_q[0].data);
      end
      a = (mq.size() != DEPTH);
      step();
      if (v && a) void'(feed_q.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    clr_underflow = 1'b0;
    mq.delete();
    exp_q.delete();
    m_cnt = 0;
    m_upd = 0;
    m_uf  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) m_dac[k] = 0;
    #1;
    compare();
    @(posedge clk);
    #1;
    compare();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    in_data = '0;
    in_ch = '0;
    in_valid = 1'b0;
    en = 1'b0;
    div = '0;
    clr_underflow = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // back-to-back pushes at div=0
    en = 1'b1;
    div = 16'd0;
    feed_q.push_back('{ch: 0, data: 'h3FF});
    feed_q.push_back('{ch: 1, data: 'h155});
    run_feed(6);
    en = 1'b0;
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;

    // pops spaced by div+1 cycles
    en = 1'b1;
    div = 16'd3;
    for (int i = 0; i < 4; i++)
      feed_q.push_back('{ch: int'($urandom_range(0, 1)), data: int'($urandom_range(0, 1023))});
    run_feed(24);

    // fill to full with ticks off, then drain across wraps
    en = 1'b0;
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    for (int i = 0; i < 9; i++)
      feed_q.push_back('{ch: i % 2, data: int'($urandom_range(0, 1023))});
    run_feed(10);
    check("full_fill", 32'(fill), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    en = 1'b1;
    div = 16'd0;
    run_feed(14);

    // underflow set and clear priority
    en = 1'b0;
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    en = 1'b1;
    div = 16'd2;
    run_feed(4);
    check("uf_set", 32'(underflow), 32'd1);
    guard = 0;
    while (m_cnt < int'(div) && guard < 8) begin step(); guard++; end
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    check("uf_set_wins", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    check("uf_cleared", 32'(underflow), 32'd0);

    // out-of-range channel is dropped
    en = 1'b1;
    div = 16'd0;
    feed_q.push_back('{ch: 3, data: 'h0AA});
    run_feed(4);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_ch    = CH_W'($urandom_range(0, 3));
      in_data  = DATA_W'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 4));
      clr_underflow = ($urandom_range(0, 9) == 0);
      step();
    end
    in_valid = 1'b0;
    clr_underflow = 1'b0;

    // reset mid-stream with five words queued
    en = 1'b0;
    step();
    while (mq.size() > 0) void'(mq.pop_front());
    do_reset();
    for (int i = 0; i < 5; i++)
      feed_q.push_back('{ch: i % 2, data: int'($urandom_range(0, 1023))});
    run_feed(6);
    check("pre_reset_fill", 32'(fill), 32'd5);
    reset = 1'b1;
    #1;
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_dac", 32'(dac_out), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_uf", 32'(underflow), 32'd0);
    do_reset();
    en = 1'b1;
    div = 16'd0;
    feed_q.push_back('{ch: 1, data: 'h2A5});
    feed_q.push_back('{ch: 0, data: 'h05A});
    run_feed(6);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
